cla_pipe_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor for the M-extension datapath.
//  - Adds the final Wallace-tree sum/carry vectors.
//  - Splits the carry chain across STAGES register stages: timing closes at any WIDTH.
//  - Adds carry-in, subtract mode, carry-out and signed overflow.
//  - Uses a valid/ready handshake so the multiplier/divider sequencers can stall it.

---
 rtl/cla_pkg.sv | 28 ++
 rtl/cla_seg.sv | 77 +++++++
 rtl/cla_pipe_adder.sv | 176 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Purpose: shared types and helpers for the pipelined carry-lookahead adder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cla_pkg;

  // Generate/propagate pair for one bit or one group of bits.
  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

  // Identity element of the merge operator: nothing generated, everything propagates.
  localparam cla_gp_t CLA_GP_ID = '{g: 1'b0, p: 1'b1};

  // Brent-Kung operator: combine a more significant span (hi) with a less significant one (lo).
  function automatic cla_gp_t cla_merge(input cla_gp_t hi, input cla_gp_t lo);
    cla_gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Bits handled by each pipeline stage.
  function automatic int cla_seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Purpose: combinational carry-lookahead adder for one pipeline segment.
// Latency: 0 cycles (pure logic).
// Backpressure: none; the enclosing stage register decides when the result is captured.
module cla_seg
  import cla_pkg::*;
#(
  parameter int SEG   = 32,
  parameter int BLOCK = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  localparam int NGRP = SEG / BLOCK;

  cla_gp_t [SEG-1:0]  bit_gp;
  logic    [SEG-1:0]  p_vec;
  cla_gp_t [NGRP-1:0] grp_gp;
  logic    [NGRP-1:0] grp_ci;
  logic    [SEG-1:0]  c;

  // Per-bit generate/propagate.
  always_comb begin
    bit_gp = '0;
    p_vec  = '0;
    for (int i = 0; i < SEG; i++) begin
      bit_gp[i].g = a[i] & b[i];
      bit_gp[i].p = a[i] ^ b[i];
      p_vec[i]    = a[i] ^ b[i];
    end
  end

  // Reduce each BLOCK-bit group to a single generate/propagate pair.
  always_comb begin
    cla_gp_t acc;
    acc    = CLA_GP_ID;
    grp_gp = '0;
    for (int j = 0; j < NGRP; j++) begin
      acc = CLA_GP_ID;
      for (int i = 0; i < BLOCK; i++) begin
        acc = cla_merge(bit_gp[j*BLOCK+i], acc);
      end
      grp_gp[j] = acc;
    end
  end

  // Lookahead across groups: carry into every group and out of the segment.
  always_comb begin
    cla_gp_t pre;
    pre    = CLA_GP_ID;
    grp_ci = '0;
    for (int j = 0; j < NGRP; j++) begin
      grp_ci[j] = pre.g | (pre.p & ci);
      pre       = cla_merge(grp_gp[j], pre);
    end
    co = pre.g | (pre.p & ci);
  end

  // Short ripple inside each group, seeded by the lookahead carry for that group.
  always_comb begin
    c = '0;
    for (int j = 0; j < NGRP; j++) begin
      c[j*BLOCK] = grp_ci[j];
      for (int i = 0; i < BLOCK - 1; i++) begin
        c[j*BLOCK+i+1] = bit_gp[j*BLOCK+i].g | (bit_gp[j*BLOCK+i].p & c[j*BLOCK+i]);
      end
    end
  end

  assign s     = p_vec ^ c;
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Purpose: pipelined carry-lookahead add/subtract with carry-out and signed overflow.
// Latency: STAGES cycles from accept to out_valid; one beat per cycle sustained.
// Backpressure: valid/ready chain; in_ready is combinational from out_ready, empty stages always fill.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = cla_seg_width(WIDTH, STAGES);

  if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_param
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK");
  end

  logic [WIDTH-1:0] bx;
  logic             c0;

  // Subtraction is a + ~b + 1, so the carry-in is forced and the user cin is ignored.
  always_comb begin
    bx = sub ? ~b : b;
    c0 = sub ? 1'b1 : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits not yet summed when entering this stage, and result bits final after it.
    localparam int OPW = WIDTH - k * SEG;
    localparam int RW  = (k + 1) * SEG;

    logic [OPW-1:0] in_a;
    logic [OPW-1:0] in_b;
    logic           in_c;
    logic           in_v;
    logic [RW-1:0]  r_new;
    logic [SEG-1:0] seg_s;
    logic           seg_co;
    logic           seg_cmsb;
    logic           rdy;
    logic           rdy_nxt;
    logic           load;
    logic           v_q, v_d;
    logic           c_q, c_d;
    logic [RW-1:0]  r_q, r_d;

    if (k == 0) begin : g_in
      assign in_a  = a;
      assign in_b  = bx;
      assign in_c  = c0;
      assign in_v  = in_valid;
      assign r_new = seg_s;
    end else begin : g_in
      assign in_a  = g_st[k-1].g_ops.a_q;
      assign in_b  = g_st[k-1].g_ops.b_q;
      assign in_c  = g_st[k-1].c_q;
      assign in_v  = g_st[k-1].v_q;
      assign r_new = {seg_s, g_st[k-1].r_q};
    end

    if (k == STAGES - 1) begin : g_rdy
      assign rdy_nxt = out_ready;
    end else begin : g_rdy
      assign rdy_nxt = g_st[k+1].rdy;
    end

    // A stage can take a new beat when it is empty or its occupant moves on this cycle.
    assign rdy  = !v_q | rdy_nxt;
    assign load = rdy & in_v;

    cla_seg #(
      .SEG   (SEG),
      .BLOCK (BLOCK)
    ) u_seg (
      .a     (in_a[SEG-1:0]),
      .b     (in_b[SEG-1:0]),
      .ci    (in_c),
      .s     (seg_s),
      .co    (seg_co),
      .c_msb (seg_cmsb)
    );

    // Valid follows upstream whenever ready; data is captured only for real beats.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      r_d = r_q;
      if (rdy) begin
        v_d = in_v;
      end
      if (load) begin
        c_d = seg_co;
        r_d = r_new;
      end
    end

    // Stage state register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        r_q <= r_d;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [OPW-SEG-1:0] a_q, a_d;
      logic [OPW-SEG-1:0] b_q, b_d;

      // Forward only the operand bits that later stages still have to add.
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load) begin
          a_d = in_a[OPW-1:SEG];
          b_d = in_b[OPW-1:SEG];
        end
      end

      // Staggered operand register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_q, ovf_d;

      // Overflow needs both carries around the top bit, which only the last segment sees.
      always_comb begin
        ovf_d = ovf_q;
        if (load) begin
          ovf_d = seg_co ^ seg_cmsb;
        end
      end

      // Overflow flag register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign in_ready  = g_st[0].rdy;
  assign out_valid = g_st[STAGES-1].v_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign sum       = g_st[STAGES-1].r_q;
  assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Purpose: self-checking bench for cla_pipe_adder in three parameterisations.
// Latency: checks STAGES-cycle accept-to-result latency per instance.
// Backpressure: drives out_ready patterns and checks ordering, stability and flush on reset.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv   [3];
  logic        ordy [3];
  logic        cin_v[3];
  logic        sub_v[3];
  logic [63:0] a_v  [3];
  logic [63:0] b_v  [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        co   [3];
  logic        of   [3];
  logic [63:0] s_v  [3];
  logic [31:0] s32;
  logic [15:0] s16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(64), .BLOCK(4), .STAGES(2)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s_v[0]), .cout(co[0]), .ovf(of[0])
  );

  cla_pipe_adder #(.WIDTH(32), .BLOCK(8), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_v[1][31:0]), .b(b_v[1][31:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s32), .cout(co[1]), .ovf(of[1])
  );

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4), .STAGES(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_v[2][15:0]), .b(b_v[2][15:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s16), .cout(co[2]), .ovf(of[2])
  );

  assign s_v[1] = {32'd0, s32};
  assign s_v[2] = {48'd0, s16};

  typedef struct {
    int          cfg;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t tbl[18];

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int width_of(input int i);
    case (i)
      0:       return 64;
      1:       return 32;
      default: return 16;
    endcase
  endfunction

  // Reference arithmetic: returns {ovf, cout, sum} for a w-bit add/subtract.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] m, aa, bb, s;
    logic [64:0] full;
    logic        c0, c, o;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = a & m;
    bb   = (sub ? ~b : b) & m;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, c0};
    s    = full[63:0] & m;
    c    = full[w];
    o    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {o, c, s};
  endfunction

  task automatic chk(input string nm, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Send one beat into an empty pipe with out_ready high and check latency and result.
  task automatic beat(input int i, input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input logic sub, input logic [63:0] es, input logic eco, input logic eov,
                      input string nm);
    int lat;
    a_v[i]   = a;
    b_v[i]   = b;
    cin_v[i] = cin;
    sub_v[i] = sub;
    ordy[i]  = 1'b1;
    iv[i]    = 1'b1;
    @(posedge clk);
    #1 iv[i] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ov[i] && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, 68'(lat), 68'(lat_of(i)));
    chk({nm, ".sum"}, {4'd0, s_v[i]}, {4'd0, es});
    chk({nm, ".cout"}, 68'(co[i]), 68'(eco));
    chk({nm, ".ovf"}, 68'(of[i]), 68'(eov));
    @(posedge clk);
    #1;
  endtask

  // Two beats in flight, one reset cycle: nothing may emerge, and the next beat is correct.
  task automatic midflight(input int i, input string nm);
    logic ghost;
    ordy[i]  = 1'b0;
    a_v[i]   = 64'h11;
    b_v[i]   = 64'h22;
    cin_v[i] = 1'b0;
    sub_v[i] = 1'b0;
    iv[i]    = 1'b1;
    @(posedge clk);
    #1 a_v[i] = 64'h33;
    @(posedge clk);
    #1 iv[i] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ordy[i] = 1'b1;
    @(negedge clk);
    chk({nm, ".sum_cleared"}, {4'd0, s_v[i]}, 68'd0);
    chk({nm, ".in_ready"}, 68'(ir[i]), 68'd1);
    ghost = ov[i];
    repeat (8) begin
      @(negedge clk);
      if (ov[i]) ghost = 1'b1;
    end
    chk({nm, ".flushed"}, 68'(ghost), 68'd0);
    @(posedge clk);
    #1;
    beat(i, 64'h1234, 64'h0F0F, 1'b1, 1'b0, 64'h2144, 1'b0, 1'b0, {nm, ".after"});
  endtask

  // Random stream on the 64-bit instance with out_ready pattern 1,0,0 repeating.
  task automatic backpressure();
    logic [65:0] q[$];
    logic [63:0] ra[10], rb[10];
    logic        rc[10], rs[10];
    logic [67:0] hv;
    logic        held, saw_stall, dup;
    int          sent, got;
    for (int n = 0; n < 10; n++) begin
      ra[n] = {$urandom, $urandom};
      rb[n] = {$urandom, $urandom};
      rc[n] = 1'($urandom_range(0, 1));
      rs[n] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; held = 1'b0; saw_stall = 1'b0; hv = '0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      @(posedge clk);
      #1;
      ordy[0] = (cyc % 3 == 0);
      if (sent < 10) begin
        iv[0] = 1'b1;
        a_v[0] = ra[sent]; b_v[0] = rb[sent]; cin_v[0] = rc[sent]; sub_v[0] = rs[sent];
      end else begin
        iv[0] = 1'b0;
      end
      @(negedge clk);
      if (held) chk("bp.hold", {ov[0], of[0], co[0], s_v[0]}, hv);
      if (!ir[0]) saw_stall = 1'b1;
      if (ov[0] && ordy[0]) begin
        if (q.size() == 0) chk("bp.extra_beat", 68'd1, 68'd0);
        else chk($sformatf("bp.beat%0d", got), {2'd0, of[0], co[0], s_v[0]}, {2'd0, q.pop_front()});
        got++;
      end
      held = ov[0] && !ordy[0];
      hv   = {1'b0, ov[0], of[0], co[0], s_v[0]};
      if (iv[0] && ir[0]) begin
        q.push_back(model(64, a_v[0], b_v[0], cin_v[0], sub_v[0]));
        sent++;
      end
    end
    chk("bp.beats_out", 68'(got), 68'd10);
    chk("bp.saw_stall", 68'(saw_stall), 68'd1);
    @(posedge clk);
    #1 iv[0] = 1'b0;
    ordy[0] = 1'b1;
    dup = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) dup = 1'b1;
    end
    chk("bp.no_duplicate", 68'(dup), 68'd0);
    chk("bp.queue_empty", 68'(q.size()), 68'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; cin_v[i] = 1'b0; sub_v[i] = 1'b0;
      a_v[i] = '0; b_v[i] = '0;
    end

    //              cfg  a                       b                       cin   sub   sum                     co    ov
    tbl[0]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                  1'b0, 1'b0, 64'h0,                  1'b1, 1'b0};
    tbl[1]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b1, 1'b0, 64'h0,                  1'b1, 1'b0};
    tbl[2]  = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                  1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3]  = '{0, 64'h5,                   64'h7,                  1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[4]  = '{0, 64'h5,                   64'h7,                  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[5]  = '{0, 64'h7,                   64'h5,                  1'b0, 1'b1, 64'h2,                  1'b1, 1'b0};
    tbl[6]  = '{0, 64'h7,                   64'h5,                  1'b1, 1'b1, 64'h2,                  1'b1, 1'b0};
    tbl[7]  = '{0, 64'h8000_0000_0000_0000, 64'h1,                  1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[8]  = '{0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 64'h0,                  1'b1, 1'b0};
    tbl[9]  = '{0, 64'h0000_0000_FFFF_FFFF, 64'h1,                  1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    tbl[10] = '{1, 64'hFFFF_FFFF,           64'h1,                  1'b0, 1'b0, 64'h0,                  1'b1, 1'b0};
    tbl[11] = '{1, 64'h7FFF_FFFF,           64'h1,                  1'b0, 1'b0, 64'h8000_0000,          1'b0, 1'b1};
    tbl[12] = '{1, 64'h5,                   64'h7,                  1'b0, 1'b1, 64'hFFFF_FFFE,          1'b0, 1'b0};
    tbl[13] = '{1, 64'h0000_FFFF,           64'h1,                  1'b0, 1'b0, 64'h0001_0000,          1'b0, 1'b0};
    tbl[14] = '{2, 64'hFFFF,                64'h1,                  1'b0, 1'b0, 64'h0,                  1'b1, 1'b0};
    tbl[15] = '{2, 64'h7FFF,                64'h1,                  1'b0, 1'b0, 64'h8000,               1'b0, 1'b1};
    tbl[16] = '{2, 64'h7,                   64'h5,                  1'b0, 1'b1, 64'h2,                  1'b1, 1'b0};
    tbl[17] = '{2, 64'h8000,                64'h1,                  1'b0, 1'b1, 64'h7FFF,               1'b1, 1'b1};

    // Reset held with a valid beat presented: nothing accepted, outputs cleared, ready high.
    iv[0] = 1'b1; a_v[0] = 64'd3; b_v[0] = 64'd4;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst%0d.out_valid", n), 68'(ov[0]), 68'd0);
      chk($sformatf("rst%0d.sum", n), {4'd0, s_v[0]}, 68'd0);
      chk($sformatf("rst%0d.in_ready", n), 68'(ir[0]), 68'd1);
    end
    chk("rst.cout", 68'(co[0]), 68'd0);
    chk("rst.ovf", 68'(of[0]), 68'd0);
    chk("rst.w32_out_valid", 68'(ov[1]), 68'd0);
    chk("rst.w16_out_valid", 68'(ov[2]), 68'd0);
    rst_n = 1'b1;
    beat(0, 64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, "rst.first");

    for (int n = 0; n < 18; n++) begin
      beat(tbl[n].cfg, tbl[n].a, tbl[n].b, tbl[n].cin, tbl[n].sub,
           tbl[n].s, tbl[n].co, tbl[n].ov, $sformatf("vec%0d_w%0d", n, width_of(tbl[n].cfg)));
    end

    backpressure();

    midflight(0, "mid_w64");
    midflight(1, "mid_w32");
    midflight(2, "mid_w16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
